// File: rtl/button_event_monitor.sv
// Front-panel Power/Reset button front end: 2-flop sync, tick-based debounce, press/release pulses, long-press levels.
// Optional BUTTON_LOCK_EN adds ButtonLock, which masks Interrupt only; debounce, FSMs and *Long keep running. No backpressure.
module button_event_monitor #(
    parameter int TICK_DIV      = 33000,
    parameter int DEBOUNCE_MS   = 16,
    parameter int LONG_PRESS_MS = 4000
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic       PowerButtonN,
    input  logic       ResetButtonN,
`ifdef BUTTON_LOCK_EN
    input  logic       ButtonLock,
`endif
    output logic [3:0] Interrupt,
    output logic [1:0] ButtonStatus,
    output logic       PowerLong,
    output logic       ResetLong
);

    localparam int TW = $clog2(TICK_DIV) + 1;
    localparam int DW = $clog2(DEBOUNCE_MS) + 1;
    localparam int HW = $clog2(LONG_PRESS_MS) + 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_MS - 1);

    localparam logic [1:0] ST_RELEASED = 2'd0;
    localparam logic [1:0] ST_PRESSED  = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    // Index 1 = Power, index 0 = Reset throughout.
    logic [TW-1:0]        r_tick_cnt;
    logic                 w_tick;
    logic [1:0]           r_meta;
    logic [1:0]           r_sync;
    logic [1:0]           w_pressed;
    logic [1:0]           r_stable;
    logic [1:0]           r_press;
    logic [1:0]           r_release;
    logic [1:0]           r_long;
    logic [1:0][DW-1:0]   r_db_cnt;
    logic [1:0][HW-1:0]   r_hold_cnt;
    logic [1:0][1:0]      r_state;
    logic [3:0]           w_irq;

    assign w_tick    = (r_tick_cnt == TICK_LAST);
    assign w_pressed = ~r_sync;

    always_ff @(posedge LpcClock) begin
        if (PciReset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Synchronisers hold the raw active-low level; reset value means "released".
    always_ff @(posedge LpcClock) begin
        if (PciReset) begin
            r_meta <= 2'b11;
            r_sync <= 2'b11;
        end else begin
            r_meta <= {PowerButtonN, ResetButtonN};
            r_sync <= r_meta;
        end
    end

    always_ff @(posedge LpcClock) begin
        if (PciReset) begin
            r_stable   <= '0;
            r_press    <= '0;
            r_release  <= '0;
            r_long     <= '0;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_state    <= {ST_RELEASED, ST_RELEASED};
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_press[i]   <= 1'b0;
                r_release[i] <= 1'b0;

                if (w_pressed[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (w_tick) begin
                    if (r_db_cnt[i] >= DB_LAST) begin
                        r_stable[i] <= w_pressed[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end

                // Release takes priority over a hold tick; a HELD release is consumed silently.
                case (r_state[i])
                    ST_RELEASED: begin
                        if (r_stable[i]) begin
                            r_state[i]    <= ST_PRESSED;
                            r_press[i]    <= 1'b1;
                            r_hold_cnt[i] <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (!r_stable[i]) begin
                            r_state[i]   <= ST_RELEASED;
                            r_release[i] <= 1'b1;
                        end else if (w_tick) begin
                            if (r_hold_cnt[i] >= HOLD_LAST) begin
                                r_state[i] <= ST_HELD;
                                r_long[i]  <= 1'b1;
                            end else begin
                                r_hold_cnt[i] <= r_hold_cnt[i] + 1'b1;
                            end
                        end
                    end
                    ST_HELD: begin
                        if (!r_stable[i]) begin
                            r_state[i] <= ST_RELEASED;
                            r_long[i]  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state[i] <= ST_RELEASED;
                        r_long[i]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign w_irq = {r_press[1], r_release[1], r_press[0], r_release[0]};

`ifdef BUTTON_LOCK_EN
    assign Interrupt = w_irq & {4{~ButtonLock}};
`else
    assign Interrupt = w_irq;
`endif

    assign ButtonStatus = r_stable;
    assign PowerLong    = r_long[1];
    assign ResetLong    = r_long[0];

endmodule
